// File: rtl/oh_clkgate_ctrl_if.sv
// oh_clkgate_ctrl_if: bundle of the clock-gate controller's activity inputs and
// gating/handshake outputs.
//   busy, wake_req, force_on, stats_clear : requester -> controller
//   clk_en, active, wake_ack, gated_cycles : controller -> requester / gate cell
// Modports: master = the side driving activity, slave = the controller.
interface oh_clkgate_ctrl_if #(
  parameter int SW = 32
);
  logic          busy;
  logic          wake_req;
  logic          force_on;
  logic          stats_clear;
  logic          clk_en;
  logic          active;
  logic          wake_ack;
  logic [SW-1:0] gated_cycles;

  modport master (
    output busy, wake_req, force_on, stats_clear,
    input  clk_en, active, wake_ack, gated_cycles
  );

  modport slave (
    input  busy, wake_req, force_on, stats_clear,
    output clk_en, active, wake_ack, gated_cycles
  );
endinterface

// File: rtl/oh_clkgate_ctrl.sv
// oh_clkgate_ctrl: idle-detect clock-gate controller, clocked by the free-running
// clock. clk_en feeds the clk-low enable latch of the domain's clock-gate cell.
// Gates the domain after IDLE_CYCLES consecutive idle cycles and restores it on
// busy, wake_req or force_on; the wake sequence holds clk_en high for WAKE_CYCLES
// cycles before the domain is reported active and wake_req is acknowledged.
// Ports:
//   clk   : free-running clock (rising edge)
//   reset : synchronous reset, active-high
//   bus   : oh_clkgate_ctrl_if.slave (busy, wake_req, force_on, stats_clear in;
//           clk_en, active, wake_ack, gated_cycles out; all outputs registered)
// Optional build macro OH_CLKGATE_STATS_EN: enables the saturating gated-cycle
// counter on gated_cycles (cleared by stats_clear). Without it gated_cycles is 0.
module oh_clkgate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int SW          = 32
) (
  input  logic                clk,
  input  logic                reset,
  oh_clkgate_ctrl_if.slave    bus
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {RUN = 2'd0, OFF = 2'd1, WAKE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [WW-1:0] wake_cnt, wake_nxt;
  logic          clk_en_q, active_q, wake_ack_q;
  logic          clk_en_d, active_d, wake_ack_d;
  logic          wake;

  assign wake = bus.busy | bus.wake_req | bus.force_on;

  // state register plus registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      idle_cnt   <= '0;
      wake_cnt   <= '0;
      clk_en_q   <= 1'b1;
      active_q   <= 1'b1;
      wake_ack_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_nxt;
      wake_cnt   <= wake_nxt;
      clk_en_q   <= clk_en_d;
      active_q   <= active_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    wake_nxt  = wake_cnt;
    unique case (state)
      RUN: begin
        if (wake) begin
          idle_nxt = '0;
        end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
          state_nxt = OFF;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      OFF: begin
        if (wake) begin
          state_nxt = WAKE;
          wake_nxt  = '0;
        end
      end
      WAKE: begin
        // not abortable: inputs are ignored until the clock has settled
        if (wake_cnt == WW'(WAKE_CYCLES - 1)) begin
          state_nxt = RUN;
          idle_nxt  = '0;
          wake_nxt  = '0;
        end else begin
          wake_nxt = wake_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        idle_nxt  = '0;
        wake_nxt  = '0;
      end
    endcase
  end

  // outputs are decoded from the next state so each one is a plain flop and
  // clk_en only moves on the rising edge (stable through the latch's low phase)
  always_comb begin
    clk_en_d   = (state_nxt != OFF);
    active_d   = (state_nxt == RUN);
    wake_ack_d = bus.wake_req & (state_nxt == RUN);
  end

  assign bus.clk_en   = clk_en_q;
  assign bus.active   = active_q;
  assign bus.wake_ack = wake_ack_q;

`ifdef OH_CLKGATE_STATS_EN
  logic [SW-1:0] gcnt;

  // counts cycles with the domain gated; clear wins over increment, saturates
  always_ff @(posedge clk) begin
    if (reset || bus.stats_clear) begin
      gcnt <= '0;
    end else if (!clk_en_q && (gcnt != {SW{1'b1}})) begin
      gcnt <= gcnt + 1'b1;
    end
  end

  assign bus.gated_cycles = gcnt;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = bus.stats_clear;
  assign bus.gated_cycles   = '0;
`endif
endmodule

// File: tb/tb_oh_clkgate_ctrl.sv
// Self-checking bench for oh_clkgate_ctrl (IDLE_CYCLES=16, WAKE_CYCLES=2, SW=4).
// Reference model tracks the domain as "gated / waking for N more edges /
// running with a run of K idle cycles" and derives the expected outputs.
module tb_oh_clkgate_ctrl;
  localparam int IC   = 16;
  localparam int WC   = 2;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oh_clkgate_ctrl_if #(.SW(SW)) bus ();

  oh_clkgate_ctrl #(.IDLE_CYCLES(IC), .WAKE_CYCLES(WC), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model
  bit m_gated;
  int m_wake_rem;
  int m_idle_run;
  bit m_ack;
  int m_stats;
  bit m_stats_en;

  initial begin
`ifdef OH_CLKGATE_STATS_EN
    m_stats_en = 1'b1;
`else
    m_stats_en = 1'b0;
`endif
  end

  wire [SW+2:0] obs = {bus.clk_en, bus.active, bus.wake_ack, bus.gated_cycles};
  logic [SW+2:0] m_exp;

  always_comb
    m_exp = {!m_gated, (!m_gated && m_wake_rem == 0), m_ack,
             m_stats_en ? SW'(m_stats) : SW'(0)};

  task automatic model_step();
    bit w;
    bit was_gated;
    w = bus.busy | bus.wake_req | bus.force_on;
    was_gated = m_gated;
    if (reset) begin
      m_gated = 0; m_wake_rem = 0; m_idle_run = 0; m_ack = 0; m_stats = 0;
      return;
    end
    if (m_wake_rem > 0) begin
      m_wake_rem--;
      if (m_wake_rem == 0) m_idle_run = 0;
    end else if (m_gated) begin
      if (w) begin
        m_gated = 0;
        m_wake_rem = WC;
      end
    end else begin
      m_idle_run = w ? 0 : m_idle_run + 1;
      if (m_idle_run == IC) begin
        m_gated = 1;
        m_idle_run = 0;
      end
    end
    m_ack = bus.wake_req && !m_gated && m_wake_rem == 0;
    if (bus.stats_clear) m_stats = 0;
    else if (was_gated && m_stats < SMAX) m_stats++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.busy = 0; bus.wake_req = 0; bus.force_on = 0; bus.stats_clear = 0;
  endtask

  task automatic go_off();
    idle_inputs();
    for (int i = 0; i < 40 && !m_gated; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    tick(); tick();
    n_chk++;
    if (obs !== {1'b1, 1'b1, 1'b0, SW'(0)})
      $display("FAIL reset_state got=%b exp=%b", obs, {1'b1, 1'b1, 1'b0, SW'(0)});
    else n_pass++;
    reset = 0;
  endtask

  task automatic test_idle_gate();
    idle_inputs();
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_chk++;
      if (bus.clk_en !== (i < IC ? 1'b1 : 1'b0))
        $display("FAIL idle_gate edge=%0d clk_en=%b exp=%b", i, bus.clk_en, (i < IC));
      else n_pass++;
      n_chk++;
      if (obs !== m_exp) $display("FAIL idle_gate_model edge=%0d got=%b exp=%b", i, obs, m_exp);
      else n_pass++;
    end
    n_chk++;
    if (bus.active !== 1'b0) $display("FAIL idle_gate_active got=%b exp=0", bus.active);
    else n_pass++;
  endtask

  task automatic test_boundary();
    reset = 1; idle_inputs(); tick(); reset = 0;
    for (int i = 0; i < IC - 1; i++) tick();
    bus.busy = 1;
    tick();
    bus.busy = 0;
    n_chk++;
    if (bus.clk_en !== 1'b1) $display("FAIL boundary_busy clk_en=%b exp=1", bus.clk_en);
    else n_pass++;
    for (int i = 1; i <= IC; i++) begin
      tick();
      n_chk++;
      if (bus.clk_en !== (i < IC ? 1'b1 : 1'b0) || obs !== m_exp)
        $display("FAIL boundary_regate edge=%0d got=%b exp=%b", i, obs, m_exp);
      else n_pass++;
    end
  endtask

  task automatic test_busy_wake();
    logic [2:0] act_seq;
    act_seq = 3'b100;  // active after edges 1,2,3
    go_off();
    bus.busy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.busy = 0;
      n_chk++;
      if (bus.clk_en !== 1'b1 || bus.active !== act_seq[i])
        $display("FAIL busy_wake edge=%0d clk_en=%b active=%b exp_active=%b",
                 i + 1, bus.clk_en, bus.active, act_seq[i]);
      else n_pass++;
    end
    for (int i = 1; i <= IC; i++) begin
      tick();
      n_chk++;
      if (bus.clk_en !== (i < IC ? 1'b1 : 1'b0) || obs !== m_exp)
        $display("FAIL busy_wake_regate edge=%0d got=%b exp=%b", i, obs, m_exp);
      else n_pass++;
    end
  endtask

  task automatic test_wake_req();
    logic [2:0] ack_seq;
    ack_seq = 3'b100;
    go_off();
    bus.wake_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.wake_ack !== ack_seq[i] || bus.clk_en !== 1'b1)
        $display("FAIL wake_req_ack edge=%0d ack=%b clk_en=%b exp_ack=%b",
                 i + 1, bus.wake_ack, bus.clk_en, ack_seq[i]);
      else n_pass++;
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_chk++;
      if (bus.clk_en !== 1'b1 || bus.wake_ack !== 1'b1)
        $display("FAIL wake_req_hold cyc=%0d clk_en=%b ack=%b exp=1/1", i, bus.clk_en, bus.wake_ack);
      else n_pass++;
    end
    bus.wake_req = 0;
    tick();
    n_chk++;
    if (bus.wake_ack !== 1'b0 || obs !== m_exp)
      $display("FAIL wake_req_drop got=%b exp=%b", obs, m_exp);
    else n_pass++;
  endtask

  task automatic test_force_on();
    bus.force_on = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_chk++;
      if (bus.clk_en !== 1'b1) $display("FAIL force_on cyc=%0d clk_en=%b exp=1", i, bus.clk_en);
      else n_pass++;
    end
    bus.force_on = 0;
    go_off();
    n_chk++;
    if (bus.clk_en !== 1'b0) $display("FAIL force_off_gate clk_en=%b exp=0", bus.clk_en);
    else n_pass++;
    reset = 1;
    tick();
    reset = 0;
    n_chk++;
    if (bus.clk_en !== 1'b1 || obs !== m_exp)
      $display("FAIL reset_in_off got=%b exp=%b", obs, m_exp);
    else n_pass++;
  endtask

  task automatic test_stats();
    go_off();
    bus.stats_clear = 1; tick(); bus.stats_clear = 0;
    for (int i = 0; i < 10; i++) tick();
    n_chk++;
    if (bus.gated_cycles !== (m_stats_en ? SW'(10) : SW'(0)))
      $display("FAIL stats_count got=%0d exp=%0d", bus.gated_cycles, m_stats_en ? 10 : 0);
    else n_pass++;
    for (int i = 0; i < 10; i++) tick();
    n_chk++;
    if (bus.gated_cycles !== (m_stats_en ? SW'(SMAX) : SW'(0)))
      $display("FAIL stats_saturate got=%0d exp=%0d", bus.gated_cycles, m_stats_en ? SMAX : 0);
    else n_pass++;
    bus.stats_clear = 1; tick(); bus.stats_clear = 0;
    n_chk++;
    if (bus.gated_cycles !== SW'(0))
      $display("FAIL stats_clear got=%0d exp=0", bus.gated_cycles);
    else n_pass++;
  endtask

  task automatic test_random();
    reset = 1; idle_inputs(); tick(); reset = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.busy        = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) bus.wake_req = ~bus.wake_req;
      if ($urandom_range(0, 79) == 0) bus.force_on = ~bus.force_on;
      bus.stats_clear = ($urandom_range(0, 59) == 0);
      reset           = ($urandom_range(0, 499) == 0);
      tick();
      n_chk++;
      if (obs !== m_exp) $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, m_exp);
      else n_pass++;
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_idle_gate();
    test_boundary();
    test_busy_wake();
    test_wake_req();
    test_force_on();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
